// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one req/ack fetch at a time and
// holds the instruction until downstream consumes it. Optional watchdog: FETCH_TIMEOUT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_nextPC,
    input  logic        i_pcsrc,
    input  logic        i_ready,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_req,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_ack,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4,
    output logic [31:0] o_instr,
    output logic        o_valid,
    output logic [31:0] o_fetch_cnt,
    output logic        o_fault
);

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;

    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            fault_q;
`else
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    // Without the watchdog the timeout length has nothing to govern.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    state_t      state;
    logic [31:0] pc_next;
    logic        unused_target_lsbs;

    // Redirect targets are forced word-aligned rather than trapping.
    assign pc_next            = i_pcsrc ? {i_nextPC[31:2], 2'b00} : o_pc + 32'd4;
    assign unused_target_lsbs = ^i_nextPC[1:0];

    assign o_imem_req  = (state == REQ);
    assign o_imem_addr = o_pc;
    assign o_pc4       = o_pc + 32'd4;

`ifdef FETCH_TIMEOUT_EN
    assign o_fault = fault_q;
`else
    assign o_fault = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            o_pc        <= RESET_PC;
            o_instr     <= 32'd0;
            o_valid     <= 1'b0;
            o_fetch_cnt <= 32'd0;
`ifdef FETCH_TIMEOUT_EN
            to_cnt      <= '0;
            fault_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
`ifdef FETCH_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
                REQ: begin
                    if (i_imem_ack) begin
                        state   <= HOLD;
                        o_instr <= i_imem_rdata;
                        o_valid <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    end else if (to_cnt == TO_LAST) begin
                        // An ack on the final allowed cycle takes priority above.
                        state   <= FAULT;
                        fault_q <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
`endif
                    end
                end
                HOLD: begin
                    if (i_ready) begin
                        state       <= REQ;
                        o_valid     <= 1'b0;
                        o_fetch_cnt <= o_fetch_cnt + 32'd1;
                        o_pc        <= pc_next;
`ifdef FETCH_TIMEOUT_EN
                        to_cnt      <= '0;
`endif
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                FAULT: begin
                    state <= FAULT;
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected fetch requests and retires,
// a monitor pops and compares them as the DUT presents them.
module tb_fetch_unit;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_nextPC = 32'd0;
    logic        i_pcsrc = 1'b0;
    logic        i_ready = 1'b0;
    logic [31:0] i_imem_rdata = 32'd0;
    logic        i_imem_ack = 1'b0;
    logic [31:0] o_imem_addr;
    logic        o_imem_req;
    logic [31:0] o_pc;
    logic [31:0] o_pc4;
    logic [31:0] o_instr;
    logic        o_valid;
    logic [31:0] o_fetch_cnt;
    logic        o_fault;

    fetch_unit #(
        .RESET_PC      (32'h0000_0000),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_nextPC    (i_nextPC),
        .i_pcsrc     (i_pcsrc),
        .i_ready     (i_ready),
        .o_imem_addr (o_imem_addr),
        .o_imem_req  (o_imem_req),
        .i_imem_rdata(i_imem_rdata),
        .i_imem_ack  (i_imem_ack),
        .o_pc        (o_pc),
        .o_pc4       (o_pc4),
        .o_instr     (o_instr),
        .o_valid     (o_valid),
        .o_fetch_cnt (o_fetch_cnt),
        .o_fault     (o_fault)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        int          len;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] cnt;
    } ret_t;

    req_t req_q[$];
    ret_t ret_q[$];

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_cnt    = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples 1 time unit before each rising edge.
    int          run_len  = 0;
    logic [31:0] run_addr = 32'd0;

    always begin
        @(negedge i_clk);
        #4;
        if (i_rst) begin
            run_len = 0;
        end else begin
            if (o_imem_req) begin
                if (run_len == 0) run_addr = o_imem_addr;
                else check("req_addr_stable", o_imem_addr, run_addr);
                run_len++;
            end else if (run_len > 0) begin
                if (req_q.size() == 0) begin
                    check("req_unexpected", run_addr, 32'hFFFF_FFFF);
                end else begin
                    req_t e;
                    e = req_q.pop_front();
                    check("req_addr", run_addr, e.addr);
                    check("req_len", 32'(run_len), 32'(e.len));
                end
                run_len = 0;
            end
            if (o_valid && i_ready) begin
                if (ret_q.size() == 0) begin
                    check("retire_unexpected", o_pc, 32'hFFFF_FFFF);
                end else begin
                    ret_t r;
                    r = ret_q.pop_front();
                    check("retire_pc", o_pc, r.pc);
                    check("retire_pc4", o_pc4, r.pc + 32'd4);
                    check("retire_instr", o_instr, r.instr);
                    check("retire_cnt", o_fetch_cnt, r.cnt);
                end
            end
        end
    end

    // One fetch: wait for the request, ack after `delay` extra cycles, optionally stall
    // `hold` cycles (with a stray ack), then consume with the given redirect.
    task automatic fetch(input logic [31:0] exp_addr, input int delay, input logic [31:0] rdata,
                         input int hold, input logic pcsrc, input logic [31:0] target);
        int n = 0;
        req_q.push_back('{addr: exp_addr, len: delay + 1});
        ret_q.push_back('{pc: exp_addr, instr: rdata, cnt: m_cnt});
        i_pcsrc  = 1'b1;
        i_nextPC = 32'hBAD0_0010;
        i_ready  = (hold == 0);
        while (!o_imem_req && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_imem_req) begin
            check("req_wait_timeout", {31'd0, o_imem_req}, 32'd1);
            return;
        end
        #1;
        repeat (delay) begin
            @(negedge i_clk);
            #1;
        end
        i_imem_ack   = 1'b1;
        i_imem_rdata = rdata;
        @(negedge i_clk);
        #1;
        i_imem_ack   = 1'b0;
        i_imem_rdata = 32'd0;
        i_pcsrc      = pcsrc;
        i_nextPC     = target;
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge i_clk);
                #1;
                i_imem_ack   = (i == 1);
                i_imem_rdata = ~rdata;
            end
            i_imem_ack = 1'b0;
            @(negedge i_clk);
            check("hold_instr", o_instr, rdata);
            check("hold_pc", o_pc, exp_addr);
            check("hold_cnt", o_fetch_cnt, m_cnt);
            check("hold_req_low", {31'd0, o_imem_req}, 32'd0);
            check("hold_valid", {31'd0, o_valid}, 32'd1);
            #1;
            i_ready = 1'b1;
        end
        @(negedge i_clk);
        #1;
        i_ready  = 1'b0;
        i_pcsrc  = 1'b0;
        i_nextPC = 32'd0;
        m_cnt    = m_cnt + 32'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=%0t required=<200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge i_clk);
        #1;
        check("rst_req", {31'd0, o_imem_req}, 32'd0);
        check("rst_pc", o_pc, 32'd0);
        check("rst_addr", o_imem_addr, 32'd0);
        check("rst_pc4", o_pc4, 32'd4);
        check("rst_instr", o_instr, 32'd0);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_cnt", o_fetch_cnt, 32'd0);
        check("rst_fault", {31'd0, o_fault}, 32'd0);
        i_rst = 1'b0;

        fetch(32'h0000_0000, 0, 32'h2008_0005, 0, 1'b0, 32'd0);
        check("first_pc", o_pc, 32'h0000_0004);
        check("first_cnt", o_fetch_cnt, 32'd1);
        check("first_valid_clear", {31'd0, o_valid}, 32'd0);
        fetch(32'h0000_0004, 3, 32'h8C09_0000, 0, 1'b0, 32'd0);
        fetch(32'h0000_0008, 3, 32'h0109_5020, 0, 1'b1, 32'h0000_0043);
        check("redirect_pc", o_pc, 32'h0000_0040);
        fetch(32'h0000_0040, 1, 32'h1000_FFFF, 0, 1'b0, 32'd0);
        check("seq_after_redirect", o_pc, 32'h0000_0044);
        fetch(32'h0000_0044, 0, 32'hAC0A_0004, 5, 1'b0, 32'd0);
        fetch(32'h0000_0048, 2, 32'h0800_0000, 0, 1'b1, 32'hFFFF_FFFF);
        check("align_pc", o_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", o_pc4, 32'h0000_0000);
        fetch(32'hFFFF_FFFC, 0, 32'h3C01_1234, 0, 1'b0, 32'd0);
        check("wrap_pc", o_pc, 32'h0000_0000);
        fetch(32'h0000_0000, 0, 32'h2402_0001, 1, 1'b0, 32'd0);
        check("cnt_8", o_fetch_cnt, 32'd8);

        // Asynchronous reset in the middle of a request, with a late ack.
        #1;
        i_rst = 1'b1;
        #1;
        check("arst_req", {31'd0, o_imem_req}, 32'd0);
        check("arst_pc", o_pc, 32'd0);
        check("arst_valid", {31'd0, o_valid}, 32'd0);
        check("arst_cnt", o_fetch_cnt, 32'd0);
        i_imem_ack   = 1'b1;
        i_imem_rdata = 32'hDEAD_BEEF;
        @(negedge i_clk);
        #1;
        i_rst = 1'b0;
        m_cnt = 32'd0;
        @(negedge i_clk);
        #1;
        i_imem_ack   = 1'b0;
        i_imem_rdata = 32'd0;
        check("late_ack_valid", {31'd0, o_valid}, 32'd0);
        check("late_ack_req", {31'd0, o_imem_req}, 32'd1);
        check("restart_addr", o_imem_addr, 32'd0);
        fetch(32'h0000_0000, 0, 32'h1234_5678, 0, 1'b0, 32'd0);
        check("restart_cnt", o_fetch_cnt, 32'd1);

`ifdef FETCH_TIMEOUT_EN
        req_q.push_back('{addr: 32'h0000_0004, len: 16});
        repeat (16) @(negedge i_clk);
        #1;
        check("to_fault", {31'd0, o_fault}, 32'd1);
        check("to_req_low", {31'd0, o_imem_req}, 32'd0);
        check("to_valid", {31'd0, o_valid}, 32'd0);
        check("to_pc_frozen", o_pc, 32'h0000_0004);
        i_imem_ack   = 1'b1;
        i_imem_rdata = 32'h0BAD_0BAD;
        @(negedge i_clk);
        #1;
        i_imem_ack = 1'b0;
        @(negedge i_clk);
        #1;
        check("to_ack_ignored", {31'd0, o_fault}, 32'd1);
        check("to_ack_no_valid", {31'd0, o_valid}, 32'd0);
        i_rst = 1'b1;
        #1;
        check("to_rst_clears", {31'd0, o_fault}, 32'd0);
        @(negedge i_clk);
        #1;
        i_rst = 1'b0;
        m_cnt = 32'd0;
        fetch(32'h0000_0000, 15, 32'h2010_0010, 0, 1'b0, 32'd0);
        check("to_edge_no_fault", {31'd0, o_fault}, 32'd0);
        check("to_edge_cnt", o_fetch_cnt, 32'd1);
`else
        fetch(32'h0000_0004, 20, 32'h2010_0010, 0, 1'b0, 32'd0);
        check("no_to_fault", {31'd0, o_fault}, 32'd0);
        check("no_to_cnt", o_fetch_cnt, 32'd2);
`endif

        repeat (3) @(negedge i_clk);
        check("req_q_drained", 32'(req_q.size()), 32'd0);
        check("ret_q_drained", 32'(ret_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
